// File: rtl/pool_writeback_unit.sv
// Result write-back stage: 2x2 max/average pooling with optional ReLU per channel,
// optional read-add-write accumulation, and per-channel plane writes to feature SRAM.
module pool_writeback_unit #(
    parameter int unsigned DW = 16,
    parameter int unsigned CH = 6,
    parameter int unsigned AW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         size_act,
    input  logic [7:0]         size_kernel,
    input  logic [AW-1:0]      addr_base,
    input  logic               pool_mode,
    input  logic               relu_en,
    input  logic               accumulate,
    input  logic               pos_clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CH*4*DW-1:0] in_data,
    output logic [AW-1:0]      sram_addr,
    output logic               sram_en,
    output logic               sram_we,
    output logic [DW-1:0]      sram_wdata,
    input  logic [DW-1:0]      sram_rdata,
    output logic               done,
    output logic               busy
);

    localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned WW = 4 * DW;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_RD      = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_ADD     = 3'd4;
    localparam logic [2:0] S_WR      = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]           state, state_d;
    logic [CW-1:0]        ch, ch_d;
    logic [7:0]           row, row_d, col, col_d;
    logic [AW-1:0]        addr_d;
    logic                 en_d, we_d, done_d;
    logic [DW-1:0]        wdata_d;

    logic signed [DW-1:0] pooled_c [CH];
    logic signed [DW-1:0] pooled_q [CH];
    logic                 acc_q, skip_q;
    logic [7:0]           fmap_q;
    logic [AW-1:0]        plane_q;

    logic                 accept_c, degen_c;
    logic [7:0]           fmap_c, row_eff_c, col_eff_c;
    logic [AW-1:0]        plane_c;
    logic signed [DW:0]   acc_sum_c;
    logic [DW-1:0]        acc_sat_c;

    // Pool one 2x2 window: signed max, or floor average of a (DW+2)-bit sum; ReLU last.
    function automatic logic signed [DW-1:0] pool_window(input logic [WW-1:0] win,
                                                         input logic avg,
                                                         input logic relu);
        logic signed [DW-1:0] e [4];
        logic signed [DW+1:0] sum;
        logic signed [DW-1:0] res;
        for (int k = 0; k < 4; k++) begin
            e[k] = win[k*DW +: DW];
        end
        sum = '0;
        res = e[0];
        for (int k = 0; k < 4; k++) begin
            sum = sum + (DW+2)'(e[k]);
        end
        for (int k = 1; k < 4; k++) begin
            if (e[k] > res) res = e[k];
        end
        if (avg) res = DW'(sum >>> 2);
        if (relu && res[DW-1]) res = '0;
        return res;
    endfunction

    assign in_ready  = (state == S_IDLE) && !rst;
    assign accept_c  = in_valid && in_ready;
    assign fmap_c    = size_act - size_kernel + 8'd1;
    assign degen_c   = (size_act < size_kernel) || (fmap_c == 8'd0);
    assign plane_c   = AW'(fmap_c) * AW'(fmap_c);
    assign row_eff_c = pos_clear ? 8'd0 : row;
    assign col_eff_c = pos_clear ? 8'd0 : col;

    always_comb begin
        for (int c = 0; c < int'(CH); c++) begin
            pooled_c[c] = pool_window(in_data[c*WW +: WW], pool_mode, relu_en);
        end
    end

    // Saturating partial-sum add against the SRAM read data.
    always_comb begin
        acc_sum_c = (DW+1)'(pooled_q[ch]) + (DW+1)'($signed(sram_rdata));
        acc_sat_c = acc_sum_c[DW-1:0];
        if (acc_sum_c[DW] != acc_sum_c[DW-1]) begin
            acc_sat_c = acc_sum_c[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    // Per-beat latches: pooled results, accumulate mode and geometry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < int'(CH); c++) pooled_q[c] <= '0;
            acc_q   <= 1'b0;
            skip_q  <= 1'b0;
            fmap_q  <= '0;
            plane_q <= '0;
        end else if (accept_c) begin
            pooled_q <= pooled_c;
            acc_q    <= accumulate;
            skip_q   <= degen_c;
            fmap_q   <= fmap_c;
            plane_q  <= plane_c;
        end
    end

    // Next state and next registered outputs; outputs reflect the state being entered.
    always_comb begin
        state_d = state;
        ch_d    = ch;
        row_d   = row;
        col_d   = col;
        addr_d  = sram_addr;
        wdata_d = sram_wdata;
        en_d    = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pos_clear) begin
                    row_d = '0;
                    col_d = '0;
                end
                if (accept_c) begin
                    ch_d = '0;
                    if (degen_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ADDR;
                        addr_d  = addr_base + AW'(row_eff_c) * AW'(fmap_c) + AW'(col_eff_c);
                    end
                end
            end
            S_ADDR: begin
                en_d = 1'b1;
                if (acc_q) begin
                    state_d = S_RD;
                end else begin
                    state_d = S_WR;
                    we_d    = 1'b1;
                    wdata_d = pooled_q[ch];
                end
            end
            S_RD: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                state_d = S_ADD;
                wdata_d = acc_sat_c;
            end
            S_ADD: begin
                state_d = S_WR;
                en_d    = 1'b1;
                we_d    = 1'b1;
            end
            S_WR: begin
                if (ch == CW'(CH - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    ch_d    = ch + CW'(1);
                    state_d = S_ADDR;
                    addr_d  = sram_addr + plane_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!skip_q) begin
                    if (col == fmap_q - 8'd1) begin
                        col_d = '0;
                        row_d = (row == fmap_q - 8'd1) ? 8'd0 : row + 8'd1;
                    end else begin
                        col_d = col + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ch         <= '0;
            row        <= '0;
            col        <= '0;
            sram_addr  <= '0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_wdata <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            ch         <= ch_d;
            row        <= row_d;
            col        <= col_d;
            sram_addr  <= addr_d;
            sram_en    <= en_d;
            sram_we    <= we_d;
            sram_wdata <= wdata_d;
            done       <= done_d;
            busy       <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_pool_writeback_unit.sv
// Bench for pool_writeback_unit: directed and random beats against a window-level
// reference model with a behavioural feature SRAM.
module tb_pool_writeback_unit;

    localparam int DW = 16;
    localparam int CH = 6;
    localparam int AW = 16;
    localparam logic [AW-1:0] BASE = 16'h1000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         size_act = 8'd28;
    logic [7:0]         size_kernel = 8'd5;
    logic [AW-1:0]      addr_base = BASE;
    logic               pool_mode = 1'b0;
    logic               relu_en = 1'b0;
    logic               accumulate = 1'b0;
    logic               pos_clear = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [CH*4*DW-1:0] in_data = '0;
    logic [AW-1:0]      sram_addr;
    logic               sram_en;
    logic               sram_we;
    logic [DW-1:0]      sram_wdata;
    logic [DW-1:0]      sram_rdata = '0;
    logic               done;
    logic               busy;

    logic [DW-1:0] mem [0:65535];
    int elem [CH][4];
    int mrow = 0;
    int mcol = 0;
    int first_addr = -1;
    int n_checks = 0;
    int n_pass = 0;

    pool_writeback_unit #(.DW(DW), .CH(CH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .size_act(size_act), .size_kernel(size_kernel),
        .addr_base(addr_base), .pool_mode(pool_mode), .relu_en(relu_en),
        .accumulate(accumulate), .pos_clear(pos_clear), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .sram_addr(sram_addr),
        .sram_en(sram_en), .sram_we(sram_we), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Feature SRAM: read data appears the cycle after the read-enable cycle.
    always @(posedge clk) begin
        if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
        if (sram_en && sram_we) mem[sram_addr] = sram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int model_pool(input int c, input bit avg, input bit relu);
        int r;
        int s;
        if (avg) begin
            s = elem[c][0] + elem[c][1] + elem[c][2] + elem[c][3];
            r = s / 4;
            if ((s % 4 != 0) && (s < 0)) r = r - 1;
        end else begin
            r = elem[c][0];
            for (int k = 1; k < 4; k++) if (elem[c][k] > r) r = elem[c][k];
        end
        if (relu && r < 0) r = 0;
        return r;
    endfunction

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic randomize_elems();
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < 4; k++)
                elem[c][k] = int'($signed(16'($urandom)));
    endtask

    task automatic run_beat(input bit pm, input bit rl, input bit ac, input int sa, input int sk,
                            input bit clr, input int abort_k, input bit disturb);
        int fmap;
        int plane;
        int per;
        int nexp;
        int p;
        bit degen;
        bit busy0;
        logic [7:0] f8;
        int e_addr [CH];
        logic [DW-1:0] e_data [CH];
        int wk[$];
        int wa[$];
        int wd[$];
        int rk[$];
        int ra[$];
        int done_k;
        int done_n;
        int ready_k;

        @(negedge clk);
        if (clr) begin
            mrow = 0;
            mcol = 0;
        end
        f8    = 8'(sa - sk + 1);
        fmap  = int'(f8);
        degen = (sa < sk) || (fmap == 0);
        plane = fmap * fmap;
        for (int c = 0; c < CH; c++) begin
            e_addr[c] = (int'(BASE) + c * plane + mrow * fmap + mcol) % 65536;
            p = model_pool(c, pm, rl);
            if (ac) p = sat(p + int'($signed(mem[e_addr[c]])));
            e_data[c] = DW'(p);
        end
        nexp = degen ? 0 : CH;
        per  = degen ? 0 : (ac ? 5 : 2);

        size_act    = 8'(sa);
        size_kernel = 8'(sk);
        pool_mode   = pm;
        relu_en     = rl;
        accumulate  = ac;
        pos_clear   = clr;
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < 4; k++)
                in_data[(c*4+k)*DW +: DW] = DW'(elem[c][k]);
        in_valid = 1'b1;
        check("ready_before_accept", 32'(in_ready), 32'd1);

        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        pos_clear = 1'b0;
        done_k  = -1;
        done_n  = 0;
        ready_k = -1;
        busy0   = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge clk);
            if (k == abort_k) begin
                #2 rst = 1'b1;
                #1;
                check("rst_sram_addr", 32'(sram_addr), 32'd0);
                check("rst_sram_en", 32'(sram_en), 32'd0);
                check("rst_sram_we", 32'(sram_we), 32'd0);
                check("rst_sram_wdata", 32'(sram_wdata), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_in_ready", 32'(in_ready), 32'd0);
                @(negedge clk);
                rst  = 1'b0;
                mrow = 0;
                mcol = 0;
                return;
            end
            if (k == 0) busy0 = busy;
            if (disturb && !degen && k == 1) begin
                pos_clear   = 1'b1;
                pool_mode   = ~pm;
                relu_en     = ~rl;
                accumulate  = ~ac;
                size_act    = 8'(sa + 3);
            end
            if (disturb && k == 2) begin
                pos_clear   = 1'b0;
                pool_mode   = pm;
                relu_en     = rl;
                accumulate  = ac;
                size_act    = 8'(sa);
            end
            if (sram_en && sram_we) begin
                wk.push_back(k);
                wa.push_back(int'(sram_addr));
                wd.push_back(int'(sram_wdata));
            end
            if (sram_en && !sram_we) begin
                rk.push_back(k);
                ra.push_back(int'(sram_addr));
            end
            if (done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (in_ready) begin
                ready_k = k;
                break;
            end
        end

        check("busy_after_accept", 32'(busy0), 32'd1);
        check("write_count", 32'(wa.size()), 32'(nexp));
        for (int i = 0; i < nexp && i < wa.size(); i++) begin
            check("write_addr", 32'(wa[i]), 32'(e_addr[i]));
            check("write_data", 32'(wd[i]), 32'(e_data[i]));
        end
        if (ac && !degen) begin
            check("read_count", 32'(ra.size()), 32'(CH));
            for (int i = 0; i < CH && i < ra.size(); i++) begin
                check("read_addr", 32'(ra[i]), 32'(e_addr[i]));
                if (i < wk.size()) check("read_to_write_gap", 32'(wk[i] - rk[i]), 32'd3);
            end
        end else begin
            check("read_count", 32'(ra.size()), 32'd0);
        end
        check("done_cycle", 32'(done_k), 32'(per * CH));
        check("done_pulses", 32'(done_n), 32'd1);
        check("ready_cycle", 32'(ready_k), 32'(per * CH + 1));
        first_addr = (wa.size() > 0) ? wa[0] : -1;

        if (!degen) begin
            mcol++;
            if (mcol == fmap) begin
                mcol = 0;
                mrow++;
                if (mrow == fmap) mrow = 0;
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = '0;
        repeat (3) @(negedge clk);
        check("reset_sram_addr", 32'(sram_addr), 32'd0);
        check("reset_sram_en", 32'(sram_en), 32'd0);
        check("reset_sram_we", 32'(sram_we), 32'd0);
        check("reset_sram_wdata", 32'(sram_wdata), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Write mode, max pooling, fmap 24
        randomize_elems();
        elem[0] = '{3, -7, 12, 5};
        elem[1] = '{-9, -2, -4, -8};
        run_beat(1'b0, 1'b0, 1'b0, 28, 5, 1'b0, -1, 1'b0);
        check("max_ch0_mem", 32'(mem[16'h1000]), 32'h0000_000C);
        check("max_ch1_mem", 32'(mem[16'h1240]), 32'h0000_FFFE);

        // Average pooling with ReLU at (0,1)
        randomize_elems();
        elem[0] = '{4, 5, 6, -3};
        elem[1] = '{-1, -2, -3, -4};
        run_beat(1'b1, 1'b1, 1'b0, 28, 5, 1'b0, -1, 1'b0);
        check("avg_ch0_mem", 32'(mem[16'h1001]), 32'h0000_0003);
        check("avg_relu_ch1_mem", 32'(mem[16'h1241]), 32'h0000_0000);

        // Accumulate with saturation at (0,2)
        randomize_elems();
        mem[16'h1002] = 16'h7FF0;
        mem[16'h1242] = 16'h0010;
        elem[0] = '{32, 1, 2, 3};
        elem[1] = '{5, 5, 5, 5};
        run_beat(1'b0, 1'b0, 1'b1, 28, 5, 1'b0, -1, 1'b0);
        check("acc_sat_ch0_mem", 32'(mem[16'h1002]), 32'h0000_7FFF);
        check("acc_ch1_mem", 32'(mem[16'h1242]), 32'h0000_0015);

        // Degenerate size: no SRAM traffic, position held
        randomize_elems();
        run_beat(1'b0, 1'b0, 1'b0, 4, 5, 1'b0, -1, 1'b0);
        randomize_elems();
        run_beat(1'b0, 1'b0, 1'b0, 28, 5, 1'b0, -1, 1'b0);
        check("after_degenerate_addr", 32'(first_addr), 32'h0000_1003);

        // Random beats: modes, sizes, coincident clears and mid-beat input changes
        for (int b = 0; b < 30; b++) begin
            randomize_elems();
            for (int a = 0; a < 8; a++) mem[$urandom_range(16'h1000, 16'h2400)] = 16'($urandom);
            run_beat(1'($urandom), 1'($urandom), 1'($urandom),
                     (b % 5 == 4) ? int'($urandom_range(0, 10)) : 28,
                     (b % 5 == 4) ? int'($urandom_range(1, 12)) : 5,
                     ($urandom_range(0, 7) == 0), -1, 1'($urandom));
        end

        // Position sequencing from an IDLE clear through a full fmap*fmap wrap
        @(negedge clk);
        pos_clear = 1'b1;
        @(negedge clk);
        pos_clear = 1'b0;
        mrow = 0;
        mcol = 0;
        for (int b = 0; b <= 576; b++) begin
            randomize_elems();
            run_beat(1'b0, 1'b0, 1'b0, 28, 5, 1'b0, -1, 1'b0);
            if (b == 0) check("clear_beat_addr", 32'(first_addr), 32'h0000_1000);
            if (b == 24) check("row1_col0_addr", 32'(first_addr), 32'h0000_1018);
            if (b == 576) check("wrap_addr", 32'(first_addr), 32'h0000_1000);
        end

        // Move off (0,0), then reset during channel 3 of an accumulate beat
        randomize_elems();
        run_beat(1'b0, 1'b0, 1'b0, 28, 5, 1'b0, -1, 1'b0);
        randomize_elems();
        run_beat(1'b0, 1'b0, 1'b1, 28, 5, 1'b0, 16, 1'b0);
        randomize_elems();
        run_beat(1'b0, 1'b0, 1'b0, 28, 5, 1'b0, -1, 1'b0);
        check("post_reset_addr", 32'(first_addr), 32'h0000_1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
